udp_frame_gen: RTL and testbench

UDP_FRAME_GEN -- requirements
Module: udp_frame_gen

---
 rtl/udp_frame_gen.sv | 120 ++++++++++++
 tb/tb_udp_frame_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/udp_frame_gen.sv
// udp_frame_gen: streams one Ethernet/IPv4/UDP frame per start pulse into a PHY byte FIFO
// Ports: pcie_clk/sys_rst clock and sync active-high reset; start + payload_len request a frame;
//        pay_valid/pay_data/pay_ready payload byte handshake; phy_din/phy_wr_en/phy_full FIFO write side;
//        busy spans accepted start through end of the inter-frame gap; frame_cnt counts completed frames.
module udp_frame_gen #(
   parameter logic [47:0] SRC_MAC     = 48'h003776_000001,
   parameter logic [47:0] DST_MAC     = 48'hffff_ffff_ffff,
   parameter logic [31:0] SRC_IP      = 32'h0a00_1565,
   parameter logic [31:0] DST_IP      = 32'h0a00_15fe,
   parameter logic [15:0] UDP_PORT    = 16'd3422,
   parameter logic [7:0]  TTL         = 8'h40,
   parameter int          MAX_PAYLOAD = 1472,
   parameter int          GAP_CYCLES  = 12
) (
   input  logic        pcie_clk,
   input  logic        sys_rst,
   input  logic        start,
   input  logic [10:0] payload_len,
   input  logic        pay_valid,
   input  logic [7:0]  pay_data,
   output logic        pay_ready,
   output logic [8:0]  phy_din,
   input  logic        phy_full,
   output logic        phy_wr_en,
   output logic        busy,
   output logic [15:0] frame_cnt
);
   typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PAD, FCS, GAP} state_t;
   state_t state, state_nx;
   logic [10:0] len, cnt, body_len;
   logic [1:0] fcs_idx;
   logic [15:0] ip_id, gap_cnt, tot_len, udp_len, ip_csum;
   logic [31:0] crc, csum_acc;
   logic [16:0] csum_f1;
   logic [335:0] hdr;
   logic [7:0] hdr_byte, fcs_byte, tx_byte;
   logic issue, last_hdr, last_pay, last_pad, last_fcs;

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? (r >> 1) ^ 32'hedb8_8320 : r >> 1;
      return r;
   endfunction

   assign tot_len  = 16'd28 + {5'd0, len};
   assign udp_len  = 16'd8 + {5'd0, len};
   // header checksum depends only on len and ip_id, both stable for the whole frame
   assign csum_acc = 32'h4500 + 32'(tot_len) + 32'(ip_id) + 32'({TTL, 8'h11})
                   + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0]) + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);
   assign csum_f1  = 17'(csum_acc[15:0]) + 17'(csum_acc[31:16]);
   assign ip_csum  = ~(csum_f1[15:0] + 16'(csum_f1[16]));
   assign hdr = {DST_MAC, SRC_MAC, 16'h0800, 16'h4500, tot_len, ip_id, 16'h0000, TTL, 8'h11,
                 ip_csum, SRC_IP, DST_IP, UDP_PORT, UDP_PORT, udp_len, 16'h0000};
   assign hdr_byte = 8'(hdr >> {6'd41 - cnt[5:0], 3'b000});
   // short frames are padded to 60 bytes before the FCS
   assign body_len = len < 11'd18 ? 11'd60 : len + 11'd42;
   assign fcs_idx  = cnt[1:0] - body_len[1:0];
   assign fcs_byte = 8'(~crc >> {fcs_idx, 3'b000});
   assign last_hdr = cnt == 11'd41;
   assign last_pay = cnt == len + 11'd41;
   assign last_pad = cnt == 11'd59;
   assign last_fcs = cnt == body_len + 11'd3;

   always_ff @(posedge pcie_clk)
      state <= sys_rst ? IDLE : state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? HDR : IDLE;
         HDR:     if (issue && last_hdr) state_nx = len == 11'd0 ? PAD : PAYLOAD;
         PAYLOAD: if (issue && last_pay) state_nx = len >= 11'd18 ? FCS : PAD;
         PAD:     if (issue && last_pad) state_nx = FCS;
         FCS:     if (issue && last_fcs) state_nx = GAP;
         GAP:     state_nx = gap_cnt <= 16'd1 ? IDLE : GAP;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      pay_ready = state == PAYLOAD && !phy_full && !sys_rst;
      issue     = !phy_full && (state inside {HDR, PAD, FCS} || (state == PAYLOAD && pay_valid));
      tx_byte   = state == HDR ? hdr_byte : state == PAYLOAD ? pay_data : state == FCS ? fcs_byte : 8'h00;
      busy      = state != IDLE;
   end

   always_ff @(posedge pcie_clk) begin
      if (sys_rst) begin
         phy_wr_en <= 1'b0;
         phy_din   <= 9'h000;
         frame_cnt <= 16'd0;
         ip_id     <= 16'd1;
         gap_cnt   <= 16'd0;
         crc       <= 32'hffff_ffff;
         len       <= 11'd0;
         cnt       <= 11'd0;
      end else begin
         phy_wr_en <= issue;
         if (issue)
            phy_din <= {1'b1, tx_byte};
         if (state == IDLE && start) begin
            len <= payload_len > 11'(MAX_PAYLOAD) ? 11'(MAX_PAYLOAD) : payload_len;
            cnt <= 11'd0;
            crc <= 32'hffff_ffff;
         end else if (issue) begin
            cnt <= cnt + 11'd1;
            if (state != FCS)
               crc <= crc_upd(crc, tx_byte);
         end
         if (issue && state == FCS && last_fcs) begin
            frame_cnt <= frame_cnt + 16'd1;
            ip_id     <= ip_id + 16'd1;
            gap_cnt   <= 16'(GAP_CYCLES);
         end else if (state == GAP)
            gap_cnt <= gap_cnt - 16'd1;
      end
   end
endmodule

// File: tb/tb_udp_frame_gen.sv
// tb_udp_frame_gen: directed checks of udp_frame_gen frame contents, lengths, stalls, gap and reset
module tb_udp_frame_gen;
   logic pcie_clk = 0, sys_rst = 1, start = 0, pay_valid = 1, phy_full = 0;
   logic [10:0] payload_len = 0;
   logic [7:0] pay_data;
   logic pay_ready, phy_wr_en, busy;
   logic [8:0] phy_din;
   logic [15:0] frame_cnt;
   int errors = 0, checks = 0, cyc = 0, flag_err = 0, full_err = 0;
   logic full_q = 0;
   logic [10:0] pidx = 0;
   logic [7:0] cap[$], ref1[$];
   int wtime[$];

   localparam logic [335:0] H1 = 336'hffffffffffff_003776000001_0800_4500_002e_0001_0000_4011_3b5c_0a001565_0a0015fe_0d5e_0d5e_001a_0000;
   localparam logic [335:0] H2 = 336'hffffffffffff_003776000001_0800_4500_001c_0002_0000_4011_3b6d_0a001565_0a0015fe_0d5e_0d5e_0008_0000;

   udp_frame_gen dut (
      .pcie_clk(pcie_clk), .sys_rst(sys_rst), .start(start), .payload_len(payload_len),
      .pay_valid(pay_valid), .pay_data(pay_data), .pay_ready(pay_ready), .phy_din(phy_din),
      .phy_full(phy_full), .phy_wr_en(phy_wr_en), .busy(busy), .frame_cnt(frame_cnt)
   );

   always #5 pcie_clk = ~pcie_clk;

   // payload source: byte k of a frame is k+1 (mod 256)
   assign pay_data = 8'(pidx + 11'd1);
   always @(posedge pcie_clk) begin
      cyc <= cyc + 1;
      full_q <= phy_full;
      if (start) pidx <= 0;
      else if (pay_valid && pay_ready) pidx <= pidx + 11'd1;
   end

   always @(negedge pcie_clk)
      if (phy_wr_en) begin
         cap.push_back(phy_din[7:0]);
         wtime.push_back(cyc);
         if (!phy_din[8]) flag_err++;
         if (full_q) full_err++;
      end

   task automatic chk(input string tag, input logic [335:0] got, input logic [335:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start(input logic [10:0] n);
      @(negedge pcie_clk);
      start = 1;
      payload_len = n;
      @(negedge pcie_clk);
      start = 0;
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (busy && k < 5000) begin
         @(negedge pcie_clk);
         k++;
      end
      chk(tag, busy, 0);
   endtask

   function automatic logic [335:0] hdr_vec();
      logic [335:0] v = 0;
      for (int i = 0; i < 42; i++) v = {v[327:0], cap[i]};
      return v;
   endfunction

   // bitwise serial CRC over every captured byte, returned in normal (unreflected) bit order
   function automatic logic [31:0] residue();
      logic [31:0] c = 32'hffffffff, r;
      logic fb;
      foreach (cap[i])
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ cap[i][b];
            c = c >> 1;
            if (fb) c = c ^ 32'hedb88320;
         end
      for (int k = 0; k < 32; k++) r[k] = c[31-k];
      return r;
   endfunction

   function automatic int diffs_vs_ref();
      int d = 0;
      for (int i = 0; i < 64; i++) if (cap[i] !== ref1[i]) d++;
      return d;
   endfunction

   initial begin
      int k, n, t_a, stall;
      logic [7:0] o;
      repeat (3) @(negedge pcie_clk);
      chk("rst_wr_en", phy_wr_en, 0);
      chk("rst_din", phy_din, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", pay_ready, 0);
      chk("rst_cnt", frame_cnt, 0);
      sys_rst = 0;

      pulse_start(18);
      wait_done("t1_done");
      chk("t1_len", cap.size(), 64);
      chk("t1_hdr", hdr_vec(), H1);
      chk("t1_pay0", cap[42], 8'h01);
      chk("t1_pay17", cap[59], 8'h12);
      chk("t1_crc", residue(), 32'hc704dd7b);
      chk("t1_fcnt", frame_cnt, 1);
      ref1 = cap;
      cap.delete();

      pulse_start(0);
      wait_done("t2_done");
      chk("t2_len", cap.size(), 64);
      chk("t2_hdr", hdr_vec(), H2);
      o = 0;
      for (int i = 42; i < 60; i++) o = o | cap[i];
      chk("t2_pad", o, 0);
      chk("t2_crc", residue(), 32'hc704dd7b);
      chk("t2_fcnt", frame_cnt, 2);
      cap.delete();

      pulse_start(2000);
      wait_done("t3_done");
      chk("t3_len", cap.size(), 1518);
      chk("t3_totlen", {cap[16], cap[17]}, 16'h05dc);
      chk("t3_csum", {cap[24], cap[25]}, 16'h35ac);
      chk("t3_udplen", {cap[38], cap[39]}, 16'h05c8);
      chk("t3_crc", residue(), 32'hc704dd7b);
      chk("t3_fcnt", frame_cnt, 3);

      @(negedge pcie_clk) sys_rst = 1;
      @(negedge pcie_clk) sys_rst = 0;
      chk("t4_rst_fcnt", frame_cnt, 0);
      cap.delete();
      pulse_start(18);
      k = 0;
      stall = 0;
      while (busy && k < 3000) begin
         @(negedge pcie_clk);
         k++;
         phy_full = 1'($urandom_range(0, 1));
         if (cap.size() >= 50 && stall < 5) begin
            pay_valid = 0;
            stall++;
         end else pay_valid = 1;
      end
      phy_full = 0;
      pay_valid = 1;
      chk("t4_done", busy, 0);
      chk("t4_len", cap.size(), 64);
      chk("t4_stream", diffs_vs_ref(), 0);
      chk("t4_full_gate", full_err, 0);
      chk("t4_fcnt", frame_cnt, 1);

      @(negedge pcie_clk) sys_rst = 1;
      @(negedge pcie_clk) sys_rst = 0;
      cap.delete();
      wtime.delete();
      pulse_start(18);
      repeat (5) @(negedge pcie_clk);
      pulse_start(18);
      wait_done("t5a_done");
      @(negedge pcie_clk);
      chk("t5_ignored_busy", busy, 0);
      chk("t5a_len", cap.size(), 64);
      chk("t5a_fcnt", frame_cnt, 1);
      t_a = wtime[63];
      cap.delete();
      wtime.delete();
      pulse_start(18);
      wait_done("t5b_done");
      chk("t5b_len", cap.size(), 64);
      chk("t5b_ipid", {cap[18], cap[19]}, 16'h0002);
      chk("t5b_gap", (wtime[0] - t_a) >= 13, 1);

      cap.delete();
      pulse_start(18);
      k = 0;
      while (cap.size() < 20 && k < 100) begin
         @(negedge pcie_clk);
         k++;
      end
      sys_rst = 1;
      @(negedge pcie_clk);
      chk("t6_wr_en", phy_wr_en, 0);
      chk("t6_busy", busy, 0);
      chk("t6_fcnt", frame_cnt, 0);
      sys_rst = 0;
      n = cap.size();
      repeat (5) @(negedge pcie_clk);
      chk("t6_no_writes", cap.size(), n);
      cap.delete();
      pulse_start(18);
      wait_done("t6_done");
      chk("t6_len", cap.size(), 64);
      chk("t6_stream", diffs_vs_ref(), 0);
      chk("t6_flags", flag_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
